// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package pipe_pkg;

    // Operand source select for the execute-stage ALU inputs
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // value read from the register file in D
        FWD_W  = 2'b01,   // bypass from the writeback-stage result
        FWD_M  = 2'b10    // bypass from the memory-stage ALU result
    } fwd_sel_t;

    // Data-memory handshake tracking
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // ResultSrcE encoding that marks a load sitting in execute
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Wait counter width; covers the whole legal MEM_TIMEOUT range (2..255)
    localparam int WAIT_CNT_W = 8;

    // True when a later stage will write the register an earlier stage reads.
    // x0 is hardwired to zero, so it never produces a hazard.
    function automatic logic reg_hit(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [2:0] we);
        return (we != 3'd0) && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Bypass mux select for one execute-stage source operand.
// Latency: combinational, same cycle.
// Backpressure: none; pure decode of the stage register fields.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic [2:0] reg_write_m,
    input  logic [2:0] reg_write_w,
    output fwd_sel_t   fwd_sel
);

    // Memory stage holds the younger result, so it wins over writeback
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_hit(rd_m, rs_e, reg_write_m)) begin
            fwd_sel = FWD_M;
        end else if (reg_hit(rd_w, rs_e, reg_write_w)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use stall, branch flush, data-memory wait with timeout.
// Latency: all stall/flush/forward outputs combinational in the same cycle; MemErr sticky after a timeout.
// Backpressure: memory wait stalls F/D/E/M and bubbles W, overriding D/E flushes until released.
// Optional: define HAZARD_PERF_CNT_EN to add the StallCnt/FlushCnt performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            Rs1E,
    input  logic [4:0]            Rs2E,
    input  logic [4:0]            RdE,
    input  logic [4:0]            RdM,
    input  logic [4:0]            RdW,
    input  logic [2:0]            RegWriteM,
    input  logic [2:0]            RegWriteW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] StallCnt,
    output logic [DATA_WIDTH-1:0] FlushCnt
`endif
);

    // Reject configurations the wait counter cannot represent
    if (DATA_WIDTH < 1 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_param
        $error("hazard_ctrl: DATA_WIDTH must be >= 1 and MEM_TIMEOUT within 2..255");
    end

    // Last wait-counter value before the access is abandoned
    localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t             state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic                  mem_err_q;

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    logic lw_stall;
    logic mem_timeout;
    logic mem_stall;

    forward_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    // Hazard detection: load-use bubble, memory wait and its timeout abort
    always_comb begin
        lw_stall    = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
        mem_timeout = (state_q == MEM_WAIT) && !MemReadyM && (wait_cnt_q == TO_LAST);
        mem_stall   = ((state_q == IDLE) && MemReqM && !MemReadyM) ||
                      ((state_q == MEM_WAIT) && !MemReadyM && !mem_timeout);
    end

    // Stage controls; a memory wait freezes E, so a pending branch or load-use
    // is still there to be resolved once the wait releases. Reset bubbles everything.
    always_comb begin
        StallF    = rst_n & (lw_stall | mem_stall);
        StallD    = rst_n & (lw_stall | mem_stall);
        StallE    = rst_n & mem_stall;
        StallM    = rst_n & mem_stall;
        FlushD    = !rst_n | (PCSrcE & !mem_stall);
        FlushE    = !rst_n | ((lw_stall | PCSrcE) & !mem_stall);
        FlushW    = !rst_n | mem_stall;
        ForwardAE = rst_n ? fwd_a : FWD_RF;
        ForwardBE = rst_n ? fwd_b : FWD_RF;
        MemErr    = mem_err_q | mem_timeout;
    end

    // Memory handshake FSM: wait for ack, give up after MEM_TIMEOUT cycles total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state_q <= IDLE;
                    end else if (mem_timeout) begin
                        state_q   <= IDLE;
                        mem_err_q <= 1'b1;
                    end else if (wait_cnt_q != TO_LAST) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters; wrap naturally at 2^DATA_WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF) begin
                StallCnt <= StallCnt + 1'b1;
            end
            if (FlushE) begin
                FlushCnt <= FlushCnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, memory wait/timeout, reset.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: memory ack timing is scripted per scenario.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [2:0]  RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .DATA_WIDTH  (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemErr     (MemErr)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
`endif
    );

    // Single comparison point: counts every check, reports any mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All memory-wait driven outputs move together
    task automatic check_mem(input string tag, input logic exp);
        check({tag, " StallF"}, 32'(StallF), 32'(exp));
        check({tag, " StallD"}, 32'(StallD), 32'(exp));
        check({tag, " StallE"}, 32'(StallE), 32'(exp));
        check({tag, " StallM"}, 32'(StallM), 32'(exp));
        check({tag, " FlushW"}, 32'(FlushW), 32'(exp));
    endtask

    task automatic clear_in();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 3'd0; RegWriteW = 3'd0; ResultSrcE = 2'd0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        // Reset with every hazard source active: outputs must still be the reset pattern
        rst_n = 1'b0;
        clear_in();
        RdM = 5'd5; RegWriteM = 3'd1; Rs1E = 5'd5;
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        PCSrcE = 1'b1; MemReqM = 1'b1;
        #12;
        check("rst StallF", 32'(StallF), 32'd0);
        check("rst StallE", 32'(StallE), 32'd0);
        check("rst FlushD", 32'(FlushD), 32'd1);
        check("rst FlushE", 32'(FlushE), 32'd1);
        check("rst FlushW", 32'(FlushW), 32'd1);
        check("rst ForwardAE", 32'(ForwardAE), 32'd0);
        check("rst MemErr", 32'(MemErr), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("rst StallCnt", StallCnt, 32'd0);
        check("rst FlushCnt", FlushCnt, 32'd0);
`endif

        @(negedge clk); rst_n = 1'b1; clear_in();

        // Forwarding: M wins over W, W alone, x0 never forwarded
        @(negedge clk);
        RdM = 5'd5; RegWriteM = 3'd1; RdW = 5'd5; RegWriteW = 3'd1; Rs1E = 5'd5;
        #1;
        check("fwd A from M", 32'(ForwardAE), 32'd2);
        check("fwd B idle", 32'(ForwardBE), 32'd0);
        @(negedge clk); Rs2E = 5'd5; #1;
        check("fwd B from M", 32'(ForwardBE), 32'd2);
        @(negedge clk); RegWriteM = 3'd0; #1;
        check("fwd A from W", 32'(ForwardAE), 32'd1);
        @(negedge clk); RegWriteM = 3'd1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; #1;
        check("fwd A x0", 32'(ForwardAE), 32'd0);
        @(negedge clk); RdW = 5'd9; RegWriteW = 3'b100; Rs2E = 5'd9; #1;
        check("fwd B from W", 32'(ForwardBE), 32'd1);

        // Load-use on Rs2D: one-cycle bubble into E, F/D held
        @(negedge clk); clear_in(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; #1;
        check("lw StallF", 32'(StallF), 32'd1);
        check("lw StallD", 32'(StallD), 32'd1);
        check("lw FlushE", 32'(FlushE), 32'd1);
        check("lw FlushD", 32'(FlushD), 32'd0);
        check("lw StallE", 32'(StallE), 32'd0);
        @(negedge clk); RdE = 5'd0; Rs2D = 5'd0; #1;
        check("lw x0 StallF", 32'(StallF), 32'd0);
        check("lw x0 FlushE", 32'(FlushE), 32'd0);
        @(negedge clk); ResultSrcE = 2'b00; RdE = 5'd7; Rs1D = 5'd7; #1;
        check("non-load StallF", 32'(StallF), 32'd0);

        // Taken branch together with a load-use
        @(negedge clk); ResultSrcE = 2'b01; PCSrcE = 1'b1; #1;
        check("br+lw FlushD", 32'(FlushD), 32'd1);
        check("br+lw FlushE", 32'(FlushE), 32'd1);
        check("br+lw StallF", 32'(StallF), 32'd1);

        // Memory ack after three low cycles; a branch during the wait is not flushed
        @(negedge clk); clear_in(); MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            PCSrcE = (i == 1);
            #1;
            check_mem("memwait", 1'b1);
            if (i == 1) begin
                check("memwait FlushD", 32'(FlushD), 32'd0);
                check("memwait FlushE", 32'(FlushE), 32'd0);
            end
        end
        @(negedge clk); PCSrcE = 1'b0; MemReadyM = 1'b1; #1;
        check_mem("memack", 1'b0);
        @(negedge clk); MemReqM = 1'b0; MemReadyM = 1'b0; #1;
        check("memack state", 32'(dut.state_q), 32'(IDLE));

        // Ack in the request cycle: no stall at all
        @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b1; #1;
        check_mem("memfast", 1'b0);
        @(negedge clk); MemReqM = 1'b0; MemReadyM = 1'b0; #1;
        check("memfast state", 32'(dut.state_q), 32'(IDLE));

        // No ack: four stall cycles, abort on the fifth with a sticky error
        @(negedge clk); MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_mem("timeout wait", 1'b1);
            check("timeout MemErr early", 32'(MemErr), 32'd0);
        end
        @(negedge clk); #1;
        check_mem("timeout release", 1'b0);
        check("timeout MemErr", 32'(MemErr), 32'd1);
        @(negedge clk); MemReqM = 1'b0; #1;
        check("timeout sticky 1", 32'(MemErr), 32'd1);
        check("timeout state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk); #1;
        check("timeout sticky 2", 32'(MemErr), 32'd1);

        // Reset mid-wait: asynchronous drop of stalls, flushes raised, error cleared
        @(negedge clk); MemReqM = 1'b1;
        @(negedge clk); #1;
        check("rstwait state", 32'(dut.state_q), 32'(MEM_WAIT));
        check_mem("rstwait pre", 1'b1);
        #2; rst_n = 1'b0; #1;
        check("rstwait StallF", 32'(StallF), 32'd0);
        check("rstwait StallM", 32'(StallM), 32'd0);
        check("rstwait FlushD", 32'(FlushD), 32'd1);
        check("rstwait FlushE", 32'(FlushE), 32'd1);
        check("rstwait FlushW", 32'(FlushW), 32'd1);
        check("rstwait MemErr", 32'(MemErr), 32'd0);
        check("rstwait state async", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk); rst_n = 1'b1; MemReqM = 1'b0; #1;
        check("post-rst state", 32'(dut.state_q), 32'(IDLE));
        check_mem("post-rst", 1'b0);
        check("post-rst FlushD", 32'(FlushD), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
